// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared defaults and entry type for the fetch sequencer
package fetch_ctrl_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          DEFAULT_MAX_OUT  = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  function automatic int ctr_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - memory port and parcel buffer handshake bundle
interface fetch_ctrl_if;

  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        buf_stall;
  logic        buf_clear;
  logic        buf_align;
  logic        buf_ready;
  logic [31:0] buf_pc;
  logic [31:0] buf_rdata;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, buf_stall,
    output buf_clear, buf_align, buf_ready, buf_pc, buf_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, buf_stall,
    input  buf_clear, buf_align, buf_ready, buf_pc, buf_rdata
  );

endinterface

// File: rtl/fetch_ctrl_queue.sv
// rtl/fetch_ctrl_queue.sv - skid FIFO holding fetched words while the buffer stalls
module fetch_queue
  import fetch_ctrl_pkg::*;
#(
  parameter  int depth = DEFAULT_MAX_OUT,
  localparam int CW    = ctr_width(depth),
  localparam int AW    = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  fetch_entry_t  mem [depth];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(depth - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset && !flush && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencer: request credit, response tracking, redirect flush
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] reset_pc = DEFAULT_RESET_PC,
  parameter int          max_out  = DEFAULT_MAX_OUT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         redir_valid,
  input  logic [31:0]  redir_pc,
  fetch_ctrl_if.master bus
);

  localparam int CW = ctr_width(max_out);

  logic [31:0]   fpc, fpc_nx;
  logic [31:0]   rpc, rpc_nx;
  logic [CW-1:0] outstanding, out_nx;
  logic [CW-1:0] discard, discard_nx;
  logic [CW-1:0] qcount;
  logic          q_push, q_pop, q_flush, q_empty, q_full;
  fetch_entry_t  q_head, q_din;
  logic          fire, accept;
  logic          redir_unused;

  assign redir_unused = redir_pc[0];

  fetch_queue #(.depth(max_out)) u_queue (
    .clock (clock),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (q_flush),
    .din   (q_din),
    .head  (q_head),
    .count (qcount),
    .empty (q_empty),
    .full  (q_full)
  );

  always_comb begin
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = '0;
    bus.buf_clear     = 1'b0;
    bus.buf_align     = 1'b0;
    bus.buf_ready     = 1'b0;
    bus.buf_pc        = '0;
    bus.buf_rdata     = '0;
    fpc_nx            = fpc;
    rpc_nx            = rpc;
    out_nx            = outstanding;
    discard_nx        = discard;
    q_push            = 1'b0;
    q_pop             = 1'b0;
    q_flush           = 1'b0;
    q_din.pc          = rpc;
    q_din.data        = bus.mem_rsp_rdata;
    fire              = 1'b0;
    accept            = 1'b0;
    if (reset) begin
      bus.mem_req_addr = fpc;
      if (redir_valid) begin
        // Everything still in flight belongs to the old stream and must be skipped.
        bus.buf_clear = 1'b1;
        bus.buf_align = redir_pc[1];
        q_flush       = 1'b1;
        out_nx        = outstanding - CW'(bus.mem_rsp_valid);
        discard_nx    = outstanding - CW'(bus.mem_rsp_valid);
        fpc_nx        = {redir_pc[31:2], 2'b00};
        rpc_nx        = {redir_pc[31:2], 2'b00};
      end else begin
        // Queued words hold credit too, so the skid queue can never overflow.
        bus.mem_req_valid = !bus.buf_stall && ((outstanding + qcount) < CW'(max_out));
        fire   = bus.mem_req_valid && bus.mem_req_ready;
        accept = bus.mem_rsp_valid && (discard == '0);
        if (bus.mem_rsp_valid && (discard != '0)) discard_nx = discard - CW'(1);
        if (accept) rpc_nx = rpc + 32'd4;
        if (fire)   fpc_nx = fpc + 32'd4;
        out_nx = outstanding + CW'(fire) - CW'(bus.mem_rsp_valid);
        if (!bus.buf_stall && !q_empty) begin
          q_pop         = 1'b1;
          q_push        = accept;
          bus.buf_ready = 1'b1;
          bus.buf_pc    = q_head.pc;
          bus.buf_rdata = q_head.data;
        end else if (!bus.buf_stall && accept) begin
          bus.buf_ready = 1'b1;
          bus.buf_pc    = rpc;
          bus.buf_rdata = bus.mem_rsp_rdata;
        end else begin
          q_push = accept;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fpc         <= reset_pc;
      rpc         <= reset_pc;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      fpc         <= fpc_nx;
      rpc         <= rpc_nx;
      outstanding <= out_nx;
      discard     <= discard_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) assert (!(q_push && q_full && !q_pop));
  end

endmodule
